// File: rtl/pipeline_stall_controller_pkg.sv
// Shared definitions for the decode-stage stall/flush sequencer: controller states,
// the hard-wired zero register and the grouped stage enable/flush bundles.
package pipeline_stall_controller_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        D_WAIT = 2'd1,
        I_WAIT = 2'd2
    } ctrlState_t;

    localparam int unsigned REG_ZERO = 0;

    typedef struct packed {
        logic pc;
        logic ifId;
        logic idEx;
        logic exMem;
    } stageWe_t;

    typedef struct packed {
        logic ifId;
        logic idEx;
        logic memWb;
    } stageFlush_t;

    // Stage enables/flushes while the D-cache refill holds everything up to EX/MEM.
    function automatic stageWe_t dMissWe();
        return stageWe_t'(4'b0000);
    endfunction

    function automatic stageFlush_t dMissFlush();
        stageFlush_t f;
        f       = '0;
        f.memWb = 1'b1;
        return f;
    endfunction

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Hazard/miss inputs and stage-control outputs of the stall controller.
// The pipeline side uses the master modport, the controller the slave modport.
interface pipeline_stall_controller_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    import pipeline_stall_controller_pkg::*;

    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic [REG_ADDR_W-1:0] ex_rt;
    logic                  ex_mem_read;
    logic                  ex_branch_taken;
    logic                  if_miss;
    logic                  if_fill_done;
    logic                  mem_miss;
    logic                  mem_fill_done;

    logic                  pc_we;
    logic                  if_id_we;
    logic                  id_ex_we;
    logic                  ex_mem_we;
    logic                  if_id_flush;
    logic                  id_ex_flush;
    logic                  mem_wb_flush;
    ctrlState_t            ctrl_state;
    logic [CNT_W-1:0]      stall_count;
    logic                  timeout_err;

    modport master (
        output id_rs, id_rt, ex_rt, ex_mem_read, ex_branch_taken,
               if_miss, if_fill_done, mem_miss, mem_fill_done,
        input  pc_we, if_id_we, id_ex_we, ex_mem_we,
               if_id_flush, id_ex_flush, mem_wb_flush,
               ctrl_state, stall_count, timeout_err
    );

    modport slave (
        input  id_rs, id_rt, ex_rt, ex_mem_read, ex_branch_taken,
               if_miss, if_fill_done, mem_miss, mem_fill_done,
        output pc_we, if_id_we, id_ex_we, ex_mem_we,
               if_id_flush, id_ex_flush, mem_wb_flush,
               ctrl_state, stall_count, timeout_err
    );

endinterface

// File: rtl/pipeline_stall_controller_load_use_detect.sv
// Load-use hazard compare between the load in EX and the sources of the instruction in ID.
// Register zero is hard-wired, so a load targeting it never creates a dependency.
module load_use_detect
    import pipeline_stall_controller_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] idRs,
    input  logic [REG_ADDR_W-1:0] idRt,
    input  logic [REG_ADDR_W-1:0] exRt,
    input  logic                  exMemRead,
    output logic                  hazard
);

    always_comb begin
        hazard = exMemRead
              && (exRt != REG_ADDR_W'(REG_ZERO))
              && ((idRs == exRt) || (idRt == exRt));
    end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Decode-stage stall/flush sequencer: merges load-use, taken-branch and cache-miss waits
// into per-stage write enables and flushes, counts stall cycles and flags hung refills.
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int REG_ADDR_W   = 5,
    parameter int CNT_W        = 16,
    parameter int MISS_TIMEOUT = 255
) (
    input  logic                         clk,
    input  logic                         reset,
    pipeline_stall_controller_if.slave   bus
);

    localparam int WAIT_W = $clog2(MISS_TIMEOUT + 1);

    ctrlState_t        state;
    ctrlState_t        stateNext;
    logic              iPending;
    logic              iPendingNext;
    logic              redirectPending;
    logic              redirectPendingNext;
    logic [WAIT_W-1:0] waitCnt;
    logic [WAIT_W-1:0] waitCntNext;
    logic [CNT_W-1:0]  stallCount;
    logic              timeoutErr;
    logic              loadUse;
    stageWe_t          we;
    stageFlush_t       flush;

    load_use_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) uLoadUse (
        .idRs      (bus.id_rs),
        .idRt      (bus.id_rt),
        .exRt      (bus.ex_rt),
        .exMemRead (bus.ex_mem_read),
        .hazard    (loadUse)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= RUN;
            iPending        <= 1'b0;
            redirectPending <= 1'b0;
        end else begin
            state           <= stateNext;
            iPending        <= iPendingNext;
            redirectPending <= redirectPendingNext;
        end
    end

    always_comb begin
        stateNext           = state;
        iPendingNext        = iPending;
        redirectPendingNext = redirectPending;
        we                  = '1;
        flush               = '0;

        case (state)
            RUN: begin
                if (bus.mem_miss) begin
                    we           = dMissWe();
                    flush        = dMissFlush();
                    stateNext    = D_WAIT;
                    iPendingNext = bus.if_miss;
                end else if (bus.ex_branch_taken) begin
                    flush.ifId = 1'b1;
                    flush.idEx = 1'b1;
                    if (bus.if_miss) begin
                        stateNext           = I_WAIT;
                        redirectPendingNext = 1'b1;
                    end
                end else if (loadUse) begin
                    // A concurrent I-miss is dropped here; the held PC refetches it.
                    we.pc      = 1'b0;
                    we.ifId    = 1'b0;
                    flush.idEx = 1'b1;
                end else if (bus.if_miss) begin
                    we.pc      = 1'b0;
                    flush.ifId = 1'b1;
                    stateNext  = I_WAIT;
                end
            end

            D_WAIT: begin
                if (bus.if_fill_done) begin
                    iPendingNext = 1'b0;
                end else if (bus.if_miss) begin
                    iPendingNext = 1'b1;
                end
                if (bus.mem_fill_done) begin
                    stateNext    = iPendingNext ? I_WAIT : RUN;
                    iPendingNext = 1'b0;
                end else begin
                    we    = dMissWe();
                    flush = dMissFlush();
                end
            end

            I_WAIT: begin
                if (bus.mem_miss) begin
                    we           = dMissWe();
                    flush        = dMissFlush();
                    stateNext    = D_WAIT;
                    iPendingNext = !bus.if_fill_done;
                end else begin
                    we.pc      = 1'b0;
                    flush.ifId = 1'b1;
                    if (bus.ex_branch_taken) begin
                        we.pc               = 1'b1;
                        flush.idEx          = 1'b1;
                        redirectPendingNext = 1'b1;
                    end
                    // A fill for a redirected fetch is wrong-path and must not enter ID.
                    if (bus.if_fill_done) begin
                        stateNext = RUN;
                        if (!(redirectPending || bus.ex_branch_taken)) begin
                            we.pc      = 1'b1;
                            we.ifId    = 1'b1;
                            flush.ifId = 1'b0;
                        end
                    end
                end
            end

            default: begin
                stateNext = RUN;
            end
        endcase

        if (stateNext == RUN) begin
            redirectPendingNext = 1'b0;
        end

        if (reset) begin
            we    = '0;
            flush = '1;
        end
    end

    // Wait streak length; starts at the first edge spent inside a wait and holds at the limit.
    always_comb begin
        waitCntNext = '0;
        if ((stateNext != RUN) && (state != RUN)) begin
            if (waitCnt != WAIT_W'(MISS_TIMEOUT)) begin
                waitCntNext = waitCnt + WAIT_W'(1);
            end else begin
                waitCntNext = waitCnt;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            waitCnt    <= '0;
            stallCount <= '0;
            timeoutErr <= 1'b0;
        end else begin
            waitCnt <= waitCntNext;
            if (!we.pc && (stallCount != '1)) begin
                stallCount <= stallCount + CNT_W'(1);
            end
            if (waitCntNext == WAIT_W'(MISS_TIMEOUT)) begin
                timeoutErr <= 1'b1;
            end
        end
    end

    assign bus.pc_we        = we.pc;
    assign bus.if_id_we     = we.ifId;
    assign bus.id_ex_we     = we.idEx;
    assign bus.ex_mem_we    = we.exMem;
    assign bus.if_id_flush  = flush.ifId;
    assign bus.id_ex_flush  = flush.idEx;
    assign bus.mem_wb_flush = flush.memWb;
    assign bus.ctrl_state   = state;
    assign bus.stall_count  = stallCount;
    assign bus.timeout_err  = timeoutErr;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Bench for pipeline_stall_controller: directed scenarios then constrained-random traffic,
// every cycle compared against a rule-level model of the controller.
module tb_pipeline_stall_controller;

    localparam int REG_ADDR_W   = 5;
    localparam int CNT_W        = 16;
    localparam int MISS_TIMEOUT = 255;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    // Model state: mode 0 = running, 1 = waiting on D-cache, 2 = waiting on I-cache.
    int mMode, nMode;
    bit mIPend, nIPend, mRedir, nRedir, mTimeout;
    int mStreak, mStalls;
    bit ePc, eIfId, eIdEx, eExMem, fIfId, fIdEx, fMemWb;

    pipeline_stall_controller_if #(.REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W)) bus ();

    pipeline_stall_controller #(
        .REG_ADDR_W   (REG_ADDR_W),
        .CNT_W        (CNT_W),
        .MISS_TIMEOUT (MISS_TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOne(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic modelEval();
        bit hz;
        hz = bus.ex_mem_read && (bus.ex_rt != 0) &&
             ((bus.id_rs == bus.ex_rt) || (bus.id_rt == bus.ex_rt));
        {ePc, eIfId, eIdEx, eExMem} = 4'b1111;
        {fIfId, fIdEx, fMemWb}      = 3'b000;
        nMode = mMode; nIPend = mIPend; nRedir = mRedir;
        if (mMode == 0) begin
            if (bus.mem_miss) begin
                {ePc, eIfId, eIdEx, eExMem} = 4'b0000; fMemWb = 1;
                nMode = 1; nIPend = bus.if_miss;
            end else if (bus.ex_branch_taken) begin
                fIfId = 1; fIdEx = 1;
                if (bus.if_miss) begin nMode = 2; nRedir = 1; end
            end else if (hz) begin
                ePc = 0; eIfId = 0; fIdEx = 1;
            end else if (bus.if_miss) begin
                ePc = 0; fIfId = 1; nMode = 2;
            end
        end else if (mMode == 1) begin
            if (bus.if_fill_done) nIPend = 0;
            else if (bus.if_miss) nIPend = 1;
            if (bus.mem_fill_done) nMode = nIPend ? 2 : 0;
            else begin
                {ePc, eIfId, eIdEx, eExMem} = 4'b0000; fMemWb = 1;
            end
        end else begin
            if (bus.mem_miss) begin
                {ePc, eIfId, eIdEx, eExMem} = 4'b0000; fMemWb = 1;
                nMode = 1; nIPend = !bus.if_fill_done;
            end else begin
                ePc = 0; fIfId = 1;
                if (bus.ex_branch_taken) begin ePc = 1; fIdEx = 1; nRedir = 1; end
                if (bus.if_fill_done) begin
                    nMode = 0;
                    if (mRedir) nRedir = 0;
                    else begin ePc = 1; eIfId = 1; fIfId = 0; end
                end
            end
        end
        if (reset) begin
            {ePc, eIfId, eIdEx, eExMem} = 4'b0000;
            {fIfId, fIdEx, fMemWb}      = 3'b111;
        end
    endtask

    task automatic checkOutput();
        checkOne("pc_we", bus.pc_we, ePc);
        checkOne("if_id_we", bus.if_id_we, eIfId);
        checkOne("id_ex_we", bus.id_ex_we, eIdEx);
        checkOne("ex_mem_we", bus.ex_mem_we, eExMem);
        checkOne("if_id_flush", bus.if_id_flush, fIfId);
        checkOne("id_ex_flush", bus.id_ex_flush, fIdEx);
        checkOne("mem_wb_flush", bus.mem_wb_flush, fMemWb);
        checkOne("ctrl_state", bus.ctrl_state, mMode);
        checkOne("stall_count", bus.stall_count, mStalls);
        checkOne("timeout_err", bus.timeout_err, mTimeout);
    endtask

    task automatic applyStimulus(input int rs, input int rt, input int exRt, input bit memRead,
                                 input bit br, input bit ifMiss, input bit ifFill,
                                 input bit memMiss, input bit memFill);
        @(negedge clk);
        bus.id_rs           = REG_ADDR_W'(rs);
        bus.id_rt           = REG_ADDR_W'(rt);
        bus.ex_rt           = REG_ADDR_W'(exRt);
        bus.ex_mem_read     = memRead;
        bus.ex_branch_taken = br;
        bus.if_miss         = ifMiss;
        bus.if_fill_done    = ifFill;
        bus.mem_miss        = memMiss;
        bus.mem_fill_done   = memFill;
        #1;
        modelEval();
        checkOutput();
    endtask

    // Streak = completed cycles of the current wait episode; the timeout fires when it reaches the limit.
    task automatic clockEdge();
        @(posedge clk);
        if (nMode == 0 || mMode == 0) mStreak = 0;
        else if (mStreak < MISS_TIMEOUT) mStreak++;
        if (mStreak == MISS_TIMEOUT) mTimeout = 1;
        if (!ePc && mStalls < (1 << CNT_W) - 1) mStalls++;
        mMode = nMode; mIPend = nIPend; mRedir = nRedir;
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic modelReset();
        mMode = 0; mIPend = 0; mRedir = 0; mTimeout = 0; mStreak = 0; mStalls = 0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOne({tag, "_state"}, bus.ctrl_state, 0);
        checkOne({tag, "_we"}, {bus.pc_we, bus.if_id_we, bus.id_ex_we, bus.ex_mem_we}, 4'b0000);
        checkOne({tag, "_flush"}, {bus.if_id_flush, bus.id_ex_flush, bus.mem_wb_flush}, 3'b111);
        checkOne({tag, "_stall_count"}, bus.stall_count, 0);
        checkOne({tag, "_timeout"}, bus.timeout_err, 0);
    endtask

    initial begin
        int s0;
        modelReset();
        reset = 1'b1;
        bus.id_rs = '0; bus.id_rt = '0; bus.ex_rt = '0; bus.ex_mem_read = 0;
        bus.ex_branch_taken = 0; bus.if_miss = 0; bus.if_fill_done = 0;
        bus.mem_miss = 0; bus.mem_fill_done = 0;
        #2;
        checkResetValues("reset");
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] load-use and zero register");
        applyStimulus(5, 0, 5, 1, 0, 0, 0, 0, 0);
        checkOne("lu_pc_we", bus.pc_we, 0);
        checkOne("lu_if_id_we", bus.if_id_we, 0);
        checkOne("lu_id_ex_flush", bus.id_ex_flush, 1);
        clockEdge();
        idleCycle();
        checkOne("lu_after_we", {bus.pc_we, bus.if_id_we, bus.id_ex_we, bus.ex_mem_we}, 4'b1111);
        clockEdge();
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);
        checkOne("zero_pc_we", bus.pc_we, 1);
        checkOne("zero_id_ex_flush", bus.id_ex_flush, 0);
        clockEdge();

        $display("[TB] D-cache miss of ten cycles");
        s0 = mStalls;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
        checkOne("dmiss_t0_flush", bus.mem_wb_flush, 1);
        clockEdge();
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, k == 10);
            checkOne("dmiss_state", bus.ctrl_state, 1);
            checkOne("dmiss_flush", bus.mem_wb_flush, k < 10);
            if (k == 10)
                checkOne("dmiss_fill_we", {bus.pc_we, bus.if_id_we, bus.id_ex_we, bus.ex_mem_we}, 4'b1111);
            clockEdge();
        end
        idleCycle();
        checkOne("dmiss_run", bus.ctrl_state, 0);
        checkOne("dmiss_stalls", bus.stall_count - s0, 10);
        clockEdge();

        $display("[TB] nested I-miss inside D-miss");
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0); clockEdge();
        idleCycle();  checkOne("nest_t1", bus.ctrl_state, 2); clockEdge();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0); checkOne("nest_t2", bus.ctrl_state, 2); clockEdge();
        idleCycle();  checkOne("nest_t3", bus.ctrl_state, 1); clockEdge();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0); clockEdge();
        idleCycle();  checkOne("nest_t5", bus.ctrl_state, 1); clockEdge();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1); clockEdge();
        idleCycle();  checkOne("nest_t7", bus.ctrl_state, 0); clockEdge();

        $display("[TB] redirect during I-miss");
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0); clockEdge();
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0); checkOne("redir_pc_we", bus.pc_we, 1); clockEdge();
        idleCycle(); clockEdge();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
        checkOne("redir_flush", bus.if_id_flush, 1);
        checkOne("redir_pc_hold", bus.pc_we, 0);
        clockEdge();
        idleCycle(); checkOne("redir_run", bus.ctrl_state, 0); clockEdge();

        $display("[TB] hung refill and asynchronous reset");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0); clockEdge();
        for (int j = 1; j <= 258; j++) begin
            idleCycle();
            if (j == 255) checkOne("timeout_early", bus.timeout_err, 0);
            if (j == 256) checkOne("timeout_rise", bus.timeout_err, 1);
            if (j == 258) checkOne("timeout_still_wait", bus.ctrl_state, 1);
            clockEdge();
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkResetValues("async_reset");
        modelReset();
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] random traffic");
        for (int i = 0; i < 1500; i++) begin
            int rs, rt, ert;
            bit mr, br, im, ifd, mm, mfd;
            rs  = $urandom_range(0, 3);
            rt  = $urandom_range(0, 3);
            ert = $urandom_range(0, 3);
            mr  = ($urandom_range(0, 1) == 1);
            br  = ($urandom_range(0, 6) == 0);
            im  = ($urandom_range(0, 7) == 0);
            mm  = ($urandom_range(0, 11) == 0);
            ifd = 0;
            mfd = 0;
            if (mMode == 2 && !mm && !br) ifd = ($urandom_range(0, 3) == 0);
            if (mMode == 1 && !mRedir)    ifd = ($urandom_range(0, 4) == 0);
            if (mMode == 1)               mfd = ($urandom_range(0, 3) == 0);
            if (ifd) im = 0;
            applyStimulus(rs, rt, ert, mr, br, im, ifd, mm, mfd);
            clockEdge();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
